// File: rtl/adder_with_cla.sv
`default_nettype none
// ============================================================================
//  Module   : adder_with_cla
//  Purpose  : WIDTH-bit unsigned adder, {cout,sum} = a + b + cin, built from
//             4-bit carry-lookahead groups plus a second lookahead level
//             across the groups. No ripple path exists between bits or
//             groups. All outputs are registered (1-cycle latency, no input
//             register, no enable).
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset, clears all outputs
//             a, b   - WIDTH-bit unsigned operands
//             cin    - carry-in
//             sum    - registered (a+b+cin) mod 2^WIDTH
//             cout   - registered carry-out (bit WIDTH of a+b+cin)
//             grp_p  - registered block propagate, &(a^b)
//             grp_g  - registered block generate (carry-out when cin=0)
//  Params   : WIDTH  - operand width, multiple of 4 (4, 8, 12, 16 ...)
//  Revision : 1.0 - initial release
// ============================================================================
module adder_with_cla #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             grp_p,
  output logic             grp_g
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g_bit;
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] c_bit;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      c_grp;

  logic [WIDTH-1:0] sum_d,   sum_q;
  logic             cout_d,  cout_q;
  logic             grp_p_d, grp_p_q;
  logic             grp_g_d, grp_g_q;

  // Flat sum-of-products carry into position n of a lookahead chain:
  //   c[n] = gen[n-1] | prop[n-1]gen[n-2] | ... | prop[n-1..0]c0
  // Each product term is formed independently, so the result is a single
  // AND-OR level rather than a chain of previously computed carries.
  function automatic logic lookahead(input logic [NG-1:0] gen,
                                     input logic [NG-1:0] prop,
                                     input logic          c0,
                                     input int            n);
    logic acc;
    logic prod;
    acc = 1'b0;
    for (int j = 0; j < n; j++) begin
      prod = gen[j];
      for (int m = j + 1; m < n; m++) begin
        prod = prod & prop[m];
      end
      acc = acc | prod;
    end
    prod = c0;
    for (int m = 0; m < n; m++) begin
      prod = prod & prop[m];
    end
    acc = acc | prod;
    return acc;
  endfunction

  assign g_bit = a & b;
  assign p_bit = a ^ b;

  // Second level: group carry-ins from (GG,GP) and cin.
  assign c_grp[0] = cin;

  generate
    for (genvar k = 1; k <= NG; k++) begin : g_grp_cin
      assign c_grp[k] = lookahead(gg, gp, cin, k);
    end
  endgenerate

  // First level: 4-bit lookahead groups.
  generate
    for (genvar k = 0; k < NG; k++) begin : g_grp
      logic [3:0] gl;
      logic [3:0] pl;
      logic       ci;

      assign gl = g_bit[4*k +: 4];
      assign pl = p_bit[4*k +: 4];
      assign ci = c_grp[k];

      assign c_bit[4*k]     = ci;
      assign c_bit[4*k + 1] = gl[0] | (pl[0] & ci);
      assign c_bit[4*k + 2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & ci);
      assign c_bit[4*k + 3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                            | (pl[2] & pl[1] & pl[0] & ci);

      assign gp[k] = &pl;
      assign gg[k] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                   | (pl[3] & pl[2] & pl[1] & gl[0]);
    end
  endgenerate

  assign sum_d   = p_bit ^ c_bit;
  assign cout_d  = c_grp[NG];
  assign grp_p_d = &gp;
  // Block generate is the top-level carry with the chain's carry-in forced to 0.
  assign grp_g_d = lookahead(gg, gp, 1'b0, NG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      grp_p_q <= 1'b0;
      grp_g_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      grp_p_q <= grp_p_d;
      grp_g_q <= grp_g_d;
    end
  end

  assign sum   = sum_q;
  assign cout  = cout_q;
  assign grp_p = grp_p_q;
  assign grp_g = grp_g_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_with_cla.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_with_cla
//  Purpose  : Scoreboard bench for adder_with_cla. Two instances (WIDTH=4 and
//             WIDTH=16) are driven every cycle; expected results from an
//             arithmetic reference model are queued at the sampling edge and
//             popped by independent monitors on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_with_cla;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        gp;
    logic        gg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  a4, b4, sum4;
  logic        cin4, cout4, gp4, gg4;
  logic [15:0] a16, b16, sum16;
  logic        cin16, cout16, gp16, gg16;

  exp_t q4[$];
  exp_t q16[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  adder_with_cla #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .cout(cout4), .grp_p(gp4), .grp_g(gg4)
  );

  adder_with_cla #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16),
    .sum(sum16), .cout(cout16), .grp_p(gp16), .grp_g(gg16)
  );

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input int w, input logic [15:0] a,
                                 input logic [15:0] b, input logic c);
    int unsigned ab, tot, mask, x;
    exp_t e;
    mask   = (32'd1 << w) - 32'd1;
    ab     = {16'b0, a} + {16'b0, b};
    tot    = ab + {31'b0, c};
    x      = {16'b0, a ^ b} & mask;
    e.sum  = 16'(tot & mask);
    e.cout = ((tot >> w) & 32'd1) != 0;
    e.gp   = (x == mask);
    e.gg   = ((ab >> w) & 32'd1) != 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every falling edge with a queued expectation pops and compares.
  always @(negedge clk) begin
    exp_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("w4 sum",   {28'b0, sum4}, {16'b0, e.sum});
      chk("w4 cout",  {31'b0, cout4}, {31'b0, e.cout});
      chk("w4 grp_p", {31'b0, gp4},   {31'b0, e.gp});
      chk("w4 grp_g", {31'b0, gg4},   {31'b0, e.gg});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q16.size() > 0) begin
      e = q16.pop_front();
      chk("w16 sum",   {16'b0, sum16}, {16'b0, e.sum});
      chk("w16 cout",  {31'b0, cout16}, {31'b0, e.cout});
      chk("w16 grp_p", {31'b0, gp16},   {31'b0, e.gp});
      chk("w16 grp_g", {31'b0, gg16},   {31'b0, e.gg});
    end
  end

  // Drive inputs, let the next rising edge sample them, queue the expectation,
  // then step 2 time units past that edge.
  task automatic issue(input logic [3:0] xa4, input logic [3:0] xb4, input logic xc4,
                       input logic [15:0] xa16, input logic [15:0] xb16, input logic xc16);
    a4 = xa4;  b4 = xb4;  cin4 = xc4;
    a16 = xa16; b16 = xb16; cin16 = xc16;
    @(posedge clk);
    q4.push_back(model(4, {12'b0, xa4}, {12'b0, xb4}, xc4));
    q16.push_back(model(16, xa16, xb16, xc16));
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " sum4"},  {28'b0, sum4},  32'd0);
    chk({tag, " cout4"}, {31'b0, cout4}, 32'd0);
    chk({tag, " gp4"},   {31'b0, gp4},   32'd0);
    chk({tag, " gg4"},   {31'b0, gg4},   32'd0);
    chk({tag, " sum16"}, {16'b0, sum16}, 32'd0);
    chk({tag, " cout16"},{31'b0, cout16},32'd0);
  endtask

  initial begin
    logic [31:0] r1, r2, r3;
    int          k;

    rst_n = 1'b0;
    a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
    a16 = 16'd0; b16 = 16'd0; cin16 = 1'b0;
    #1;
    chk_zero("initial reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Basic and carry-out cases on the 4-bit instance, boundaries on the 16-bit.
    issue(4'd0,  4'd0,  1'b0, 16'h00FF, 16'h0001, 1'b0);
    issue(4'd2,  4'd1,  1'b0, 16'hFFFF, 16'h0001, 1'b0);
    issue(4'd4,  4'd10, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    issue(4'd2,  4'd2,  1'b0, 16'hFFFF, 16'h0000, 1'b1);
    issue(4'd10, 4'd10, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
    issue(4'd15, 4'd15, 1'b0, 16'h0000, 16'h0000, 1'b0);
    issue(4'd15, 4'd0,  1'b1, 16'h8000, 16'h8000, 1'b0);
    issue(4'd15, 4'd0,  1'b0, 16'h0F0F, 16'hF0F0, 1'b1);
    issue(4'd15, 4'd15, 1'b1, 16'h1234, 16'h4321, 1'b1);

    // Latency: outputs hold 2+1 while inputs wander before the next edge.
    issue(4'd2, 4'd1, 1'b0, 16'd0, 16'd0, 1'b0);
    a4 = 4'd5; b4 = 4'd6;
    #2;
    chk("hold sum4 a", {28'b0, sum4}, 32'd3);
    a4 = 4'd7; b4 = 4'd8; cin4 = 1'b1;
    #1;
    chk("hold sum4 b", {28'b0, sum4}, 32'd3);
    chk("hold cout4",  {31'b0, cout4}, 32'd0);
    issue(4'd7, 4'd8, 1'b1, 16'd0, 16'd0, 1'b0);

    // Asynchronous reset mid-cycle with 9+9 loaded.
    issue(4'd9, 4'd9, 1'b0, 16'h0009, 16'h0009, 1'b0);
    @(negedge clk);
    #1;
    chk("pre-reset sum4", {28'b0, sum4}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    @(posedge clk);
    #1;
    chk_zero("reset held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("release sum4",  {28'b0, sum4},  32'd2);
    chk("release cout4", {31'b0, cout4}, 32'd1);

    // Random vectors.
    for (int i = 0; i < 1000; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      r3 = $urandom;
      issue(r1[3:0], r1[7:4], r3[0], r2[15:0], r2[31:16], r3[1]);
    end

    k = 0;
    while ((q4.size() > 0 || q16.size() > 0) && k < 10) begin
      @(negedge clk);
      k++;
    end
    #1;
    checks++;
    if (q4.size() > 0 || q16.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d results still queued, expected 0", q4.size(), q16.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
